// File: rtl/int8_mac_pkg.sv
// Shared types and constants for the int8 dual-lane MAC sequencer.
// Word layout is {w1,a1,w0,a0}; dequant scale is Q8.16.
package int8_mac_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_STREAM = 3'd2;
  localparam state_t ST_FLUSH  = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;
  localparam state_t ST_RESP   = 3'd5;

  localparam int A0_LSB   = 0;
  localparam int W0_LSB   = 8;
  localparam int A1_LSB   = 16;
  localparam int W1_LSB   = 24;
  localparam int Q_FRAC_W = 16;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] a;
  } lane_op_t;

  function automatic lane_op_t word_lane(input logic [31:0] word, input logic lane);
    lane_op_t op;
    op.w = lane ? word[W1_LSB +: 8] : word[W0_LSB +: 8];
    op.a = lane ? word[A1_LSB +: 8] : word[A0_LSB +: 8];
    return op;
  endfunction

endpackage

// File: rtl/int8_pair_zero_gate.sv
// Splits one SRAM word into two MAC lanes, dropping out-of-range and zero-product
// elements and reporting how many in-range elements were skipped.
module int8_pair_zero_gate
  import int8_mac_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  in_range,
  output logic [1:0]  lane_valid,
  output logic [7:0]  w0,
  output logic [7:0]  a0,
  output logic [7:0]  w1,
  output logic [7:0]  a1,
  output logic [1:0]  skip
);

  lane_op_t op0, op1;

  always_comb begin
    op0 = word_lane(word, 1'b0);
    op1 = word_lane(word, 1'b1);
    lane_valid[0] = in_range[0] && (op0.w != 8'd0) && (op0.a != 8'd0);
    lane_valid[1] = in_range[1] && (op1.w != 8'd0) && (op1.a != 8'd0);
    w0 = lane_valid[0] ? op0.w : 8'd0;
    a0 = lane_valid[0] ? op0.a : 8'd0;
    w1 = lane_valid[1] ? op1.w : 8'd0;
    a1 = lane_valid[1] ? op1.a : 8'd0;
    // out-of-range elements are masked, not skipped
    skip = {1'b0, in_range[0] & ~lane_valid[0]} + {1'b0, in_range[1] & ~lane_valid[1]};
  end

endmodule

// File: rtl/int8_dual_mac_sequencer.sv
// Job controller for int8_dual_zero_skip_mac: streams packed pairs from SRAM,
// flushes the MAC with zero beats, and returns the dequantized dot product.
module int8_dual_mac_sequencer
  import int8_mac_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int LEN_W       = 16,
  parameter int ACC_WIDTH   = 48,
  parameter int SCALE_WIDTH = 24,
  parameter int FLUSH_BEATS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  output logic                   busy,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [31:0]            mem_rdata,
  output logic                   mac_clear_acc,
  output logic                   mac_valid0,
  output logic                   mac_valid1,
  output logic                   mac_last0,
  output logic                   mac_last1,
  output logic [7:0]             mac_weight0,
  output logic [7:0]             mac_weight1,
  output logic [7:0]             mac_act0,
  output logic [7:0]             mac_act1,
  output logic [SCALE_WIDTH-1:0] mac_scale,
  input  logic [ACC_WIDTH-1:0]   mac_dq,
  input  logic                   mac_dq_valid,
  output logic [ACC_WIDTH-1:0]   res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [LEN_W-1:0]       skip_cnt
);

  localparam int FL_W = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [FL_W-1:0]        fl_q, fl_d;
  logic                   pend_q, pend_d;
  logic [1:0]             mask_q, mask_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic [LEN_W-1:0]       skip_q, skip_d;
  logic [ACC_WIDTH-1:0]   res_q, res_d;

  logic [1:0] g_valid, g_skip, g_range;
  logic [7:0] g_w0, g_a0, g_w1, g_a1;
  logic       last_word, flush_beat, flush_final;

  // pend_q marks the cycle where the previous cycle's read data is on mem_rdata
  assign g_range = pend_q ? mask_q : 2'b00;

  int8_pair_zero_gate u_gate (
    .word       (mem_rdata),
    .in_range   (g_range),
    .lane_valid (g_valid),
    .w0         (g_w0),
    .a0         (g_a0),
    .w1         (g_w1),
    .a1         (g_a1),
    .skip       (g_skip)
  );

  always_comb begin
    last_word   = (rem_q <= LEN_W'(2));
    // flush beats wait until the trailing data beat has drained
    flush_beat  = (state_q == ST_FLUSH) && !pend_q;
    flush_final = flush_beat && (fl_q == FL_W'(FLUSH_BEATS - 1));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    fl_d    = fl_q;
    pend_d  = 1'b0;
    mask_d  = 2'b00;
    scale_d = scale_q;
    skip_d  = skip_q + LEN_W'(g_skip);
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          addr_d  = cfg_base;
          rem_d   = cfg_len;
          scale_d = cfg_scale;
          skip_d  = '0;
          fl_d    = '0;
        end
      end
      ST_CLEAR: state_d = (rem_q == '0) ? ST_FLUSH : ST_STREAM;
      ST_STREAM: begin
        pend_d = 1'b1;
        mask_d = (rem_q == LEN_W'(1)) ? 2'b01 : 2'b11;
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = last_word ? '0 : rem_q - LEN_W'(2);
        if (last_word) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_beat) begin
          fl_d = fl_q + FL_W'(1);
          if (flush_final) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mac_dq_valid) begin
          res_d   = mac_dq;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      fl_q    <= '0;
      pend_q  <= 1'b0;
      mask_q  <= 2'b00;
      scale_q <= '0;
      skip_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      fl_q    <= fl_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      scale_q <= scale_d;
      skip_q  <= skip_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    mem_rd_en     = (state_q == ST_STREAM);
    mem_addr      = mem_rd_en ? addr_q : '0;
    mac_clear_acc = (state_q == ST_CLEAR);
    mac_valid0    = g_valid[0] | flush_beat;
    mac_valid1    = g_valid[1];
    mac_last0     = flush_final;
    mac_last1     = 1'b0;
    mac_weight0   = g_w0;
    mac_act0      = g_a0;
    mac_weight1   = g_w1;
    mac_act1      = g_a1;
    mac_scale     = scale_q;
    res_data      = res_q;
    res_valid     = (state_q == ST_RESP);
    skip_cnt      = skip_q;
  end

endmodule

// File: tb/tb_int8_dual_mac_sequencer.sv
// Scoreboard bench: directed jobs push hand-computed results; a negedge monitor
// checks each result handshake, per-job strobe counts, hold stability and reset.
module tb_int8_dual_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] cfg_base = '0;
  logic [15:0] cfg_len = '0;
  logic [23:0] cfg_scale = '0;
  logic        busy, mem_rd_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mac_clear_acc, mac_valid0, mac_valid1, mac_last0, mac_last1;
  logic [7:0]  mac_weight0, mac_weight1, mac_act0, mac_act1;
  logic [23:0] mac_scale;
  logic [47:0] mac_dq = '0;
  logic        mac_dq_valid = 1'b0;
  logic [47:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] skip_cnt;

  always #5 clk = ~clk;

  int8_dual_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_scale(cfg_scale), .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mac_clear_acc(mac_clear_acc), .mac_valid0(mac_valid0),
    .mac_valid1(mac_valid1), .mac_last0(mac_last0), .mac_last1(mac_last1),
    .mac_weight0(mac_weight0), .mac_weight1(mac_weight1), .mac_act0(mac_act0),
    .mac_act1(mac_act1), .mac_scale(mac_scale), .mac_dq(mac_dq),
    .mac_dq_valid(mac_dq_valid), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .skip_cnt(skip_cnt)
  );

  // SRAM with one-cycle read latency
  logic [31:0] mem [4096];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Behavioural MAC: dequantizes the pre-update accumulator on last
  logic signed [47:0] acc = '0;
  logic signed [15:0] p0, p1;
  assign p0 = $signed(mac_weight0) * $signed(mac_act0);
  assign p1 = $signed(mac_weight1) * $signed(mac_act1);

  function automatic logic [47:0] dq_f(input logic signed [47:0] a, input logic [23:0] s);
    longint p;
    p = longint'(a) * longint'({40'd0, s});
    return 48'(p >>> 16);
  endfunction

  always @(posedge clk) begin
    mac_dq_valid <= 1'b0;
    if (rst || mac_clear_acc) acc <= '0;
    else begin
      if (mac_last0 || mac_last1) begin
        mac_dq       <= dq_f(acc, mac_scale);
        mac_dq_valid <= 1'b1;
      end
      acc <= acc + (mac_valid0 ? 48'(p0) : 48'sd0) + (mac_valid1 ? 48'(p1) : 48'sd0);
    end
  end

  typedef struct {
    longint res;
    int     skip;
    int     rd;
    int     v0;
    int     v1;
    int     last;
  } exp_t;

  exp_t exp_q[$];
  int vec = 0, mis = 0;
  int n_rd = 0, n_v0 = 0, n_v1 = 0, n_last = 0, n_clr = 0, n_ovl = 0;
  int b_rd = 0, b_v0 = 0, b_v1 = 0, b_last = 0, b_clr = 0, b_ovl = 0;
  logic        rst_d = 1'b0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0;
  logic [47:0] prev_data = '0;

  always @(posedge clk) rst_d <= rst;

  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic hs;
    if (rst_d) begin
      chk("reset_outputs", longint'(|{busy, mem_rd_en, mem_addr, mac_clear_acc, mac_valid0,
          mac_valid1, mac_last0, mac_last1, mac_weight0, mac_weight1, mac_act0, mac_act1,
          mac_scale, res_data, res_valid, skip_cnt}), 0);
      b_rd = n_rd; b_v0 = n_v0; b_v1 = n_v1; b_last = n_last; b_clr = n_clr; b_ovl = n_ovl;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      n_rd   += int'(mem_rd_en);
      n_v0   += int'(mac_valid0);
      n_v1   += int'(mac_valid1);
      n_last += int'(mac_last0) + int'(mac_last1);
      n_clr  += int'(mac_clear_acc);
      n_ovl  += int'(mac_clear_acc & (mac_valid0 | mac_valid1));
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", longint'(res_valid), 1);
        chk("hold_data", longint'(res_data), longint'(prev_data));
      end
      hs = res_valid && res_ready;
      if (hs) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("res_data", longint'($signed(res_data)), e.res);
          chk("skip_cnt", longint'(skip_cnt), longint'(e.skip));
          chk("mem_reads", longint'(n_rd - b_rd), longint'(e.rd));
          chk("valid0_beats", longint'(n_v0 - b_v0), longint'(e.v0));
          chk("valid1_beats", longint'(n_v1 - b_v1), longint'(e.v1));
          chk("last_beats", longint'(n_last - b_last), longint'(e.last));
          chk("clear_beats", longint'(n_clr - b_clr), 1);
          chk("clear_overlap", longint'(n_ovl - b_ovl), 0);
        end
        b_rd = n_rd; b_v0 = n_v0; b_v1 = n_v1; b_last = n_last; b_clr = n_clr; b_ovl = n_ovl;
      end
      prev_valid = res_valid;
      prev_hs    = hs;
      prev_data  = res_data;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start, then scrambles cfg so later changes must not matter.
  task automatic kick(input logic [11:0] base, input logic [15:0] len, input logic [23:0] sc);
    start = 1'b1; cfg_base = base; cfg_len = len; cfg_scale = sc;
    tick();
    start = 1'b0; cfg_base = ~base; cfg_len = len + 16'd7; cfg_scale = 24'h0F0F0F;
  endtask

  task automatic issue(input logic [11:0] base, input logic [15:0] len, input logic [23:0] sc,
                       input longint res, input int skip, input int rd, input int v0,
                       input int v1);
    exp_t e;
    e.res = res; e.skip = skip; e.rd = rd; e.v0 = v0; e.v1 = v1; e.last = 1;
    exp_q.push_back(e);
    kick(base, len, sc);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy) begin
      tick();
      c++;
      if (c > 300) begin
        $display("FAIL %s: busy still high after %0d cycles", nm, c);
        $fatal(1);
      end
    end
  endtask

  initial begin
    int c;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'h02060105; mem[12'h011] = 32'h04080307;
    mem[12'h020] = 32'h02060005; mem[12'h021] = 32'h00000307;
    mem[12'h030] = 32'h02060105; mem[12'h031] = 32'h04080307;
    mem[12'hFFF] = 32'hFE0304FB; mem[12'h000] = 32'h01010202;
    mem[12'h060] = 32'h01010101; mem[12'h061] = 32'hFF020303; mem[12'h062] = 32'h050502FE;

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1*5+2*6+3*7+4*8
    issue(12'h010, 16'd4, 24'h010000, 70, 0, 2, 3, 2);  wait_idle("basic");
    // w0=0 in word0, lane1 zero in word1: 2*6 + 3*7
    issue(12'h020, 16'd4, 24'h010000, 33, 2, 2, 2, 1);  wait_idle("zero_skip");
    // odd length masks lane1 of word1
    issue(12'h030, 16'd3, 24'h010000, 38, 0, 2, 3, 1);  wait_idle("odd_len");
    issue(12'h040, 16'd0, 24'h010000, 0, 0, 0, 1, 0);   wait_idle("len0");
    issue(12'h050, 16'd8, 24'h010000, 0, 8, 4, 1, 0);   wait_idle("all_zero");
    // wrap 0xFFF->0x000: (-20-6+4+1)*2.0
    issue(12'hFFF, 16'd4, 24'h020000, -42, 0, 2, 3, 2); wait_idle("wrap");

    // result stall with an ignored start, then a back-to-back job
    res_ready = 1'b0;
    issue(12'h010, 16'd4, 24'h008000, 35, 0, 2, 3, 2);
    c = 0;
    while (!res_valid) begin
      tick();
      c++;
      if (c > 300) begin
        $display("FAIL stall: res_valid never rose after %0d cycles", c);
        $fatal(1);
      end
    end
    tick(3);
    kick(12'h050, 16'd8, 24'h010000);
    tick(6);
    res_ready = 1'b1;
    wait_idle("stall");
    issue(12'h020, 16'd4, 24'h010000, 33, 2, 2, 2, 1);  wait_idle("back_to_back");

    // reset mid-STREAM aborts the job; the next job must be clean
    kick(12'h060, 16'd16, 24'h010000);
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);
    // 2 + (9-2) + (2*-2), lane1 of word2 masked
    issue(12'h060, 16'd5, 24'h010000, 5, 0, 3, 4, 2);   wait_idle("after_rst");

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
